unified_mem_arbiter: RTL
========================

Name: unified_mem_arbiter

Overview:
- Shares one single-ported unified memory between the MIPS core's instruction-fetch port and its data port.
- Sits between the core (instr_addr/instr_in, data_addr/data_out/data_in/data_rd_wr) and the memory model. The core stalls on fetch/data until the arbiter returns valid data.
- Fixed priority: data over instruction. A starvation guard forces an instruction grant after a bounded number of data grants.
- One access in flight at a time; fixed memory read latency.

Parameters:
- MEM_LAT, 2: cycles from the mem_en cycle to the cycle mem_rdata is valid; legal range 1..15.
- STARVE_MAX, 4: consecutive data grants allowed while i_req is pending before instruction wins; legal range 1..15.

Ports:
- clk  in  1  clock
- reset  in  1  reset
- i_req  in  1  instruction read request; held until i_gnt
- i_addr  in  32  instruction address
- i_gnt  out  1  one-cycle instruction grant
- i_rvalid  out  1  one-cycle pulse; i_rdata valid
- i_rdata  out  32  instruction word
- d_req  in  1  data request; held until d_gnt
- d_we  in  1  1 = write, 0 = read
- d_addr  in  32  data address
- d_wdata  in  32  store data
- d_gnt  out  1  one-cycle data grant
- d_rvalid  out  1  one-cycle pulse; d_rdata valid (reads only)
- d_rdata  out  32  load data
- mem_en  out  1  memory access strobe, one cycle
- mem_we  out  1  write enable, qualified by mem_en
- mem_addr  out  32  memory address
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data
- err  out  1  alignment error pulse (see Optional Feature)
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: reset, synchronous, active-high; clock clk. On reset all outputs are 0, state goes to IDLE, and starve_cnt goes to 0.
- Reset mid-access aborts the access: no rvalid is produced and nothing is retried.
- All outputs are registered.
- States:
  - IDLE: arbitrate.
  - RD_WAIT: count MEM_LAT.
  - RD_RESP: capture mem_rdata.
  - WR: single cycle.
- IDLE, request sampled at edge of cycle N:
  - Winner gets gnt=1, mem_en=1, mem_addr, mem_we and mem_wdata, all in cycle N+1.
  - Addresses and data are latched at the edge; the requester may change them after it sees gnt.
- Arbitration:
  - Only d_req high: data wins.
  - Only i_req high: instruction wins.
  - Both high: data wins, unless starve_cnt == STARVE_MAX, in which case instruction wins.
  - A req dropped before its grant is legal; IDLE re-evaluates every cycle.
- starve_cnt:
  - Increments (saturating at STARVE_MAX) on each data grant made while i_req is high.
  - Clears on any instruction grant.
  - Holds otherwise.
- Read sequence: grant cycle N+1 (mem_en), then RD_WAIT, then mem_rdata sampled in cycle N+MEM_LAT+1.
  - i_rdata/d_rdata and the matching rvalid are high in cycle N+MEM_LAT+2.
  - State is IDLE in that same cycle, so the next grant is at the earliest in cycle N+MEM_LAT+3.
- Write sequence (d_we=1): mem_we=1 and mem_wdata=d_wdata in cycle N+1. No rvalid is produced. IDLE in N+2, next grant at the earliest in N+3.
- Instruction requests are always reads; i_req has no write path.
- Requests arriving while busy are ignored until IDLE and are not queued. A requester holding req through a busy period is served from IDLE.
- rdata outputs hold their last value between rvalid pulses.
- mem_we is 0 whenever mem_en is 0.

Optional Feature:
- Macro ARB_ALIGN_CHECK_EN.
- Defined:
  - Any granted address with addr[1:0] != 0 is not issued: mem_en stays 0.
  - gnt still pulses in cycle N+1 and err pulses in cycle N+1.
  - The rvalid for that request is never produced; state returns to IDLE in N+2.
  - starve_cnt updates as for a normal grant.
- Undefined: err is tied to 0, and addresses pass through unchanged with no check.

Test Plan (MEM_LAT=2, STARVE_MAX=4):
- d_req=1, d_we=0, d_addr=0x100 at cycle 0; mem_rdata=0xDEADBEEF in cycle 3 -> d_gnt=1, mem_en=1, mem_addr=0x100 in cycle 1; d_rvalid=1, d_rdata=0xDEADBEEF in cycle 4; i_* stays idle.
- d_req=1, d_we=1, d_addr=0x200, d_wdata=0x12345678 -> mem_en=1, mem_we=1, mem_wdata=0x12345678 in cycle 1; no d_rvalid; busy low in cycle 2.
- i_req and d_req held continuously, all data reads -> grant order D,D,D,D,I,D,D,D,D,I; starve_cnt returns to 0 after each I grant.
- i_req=1, i_addr=0x400 at cycle 0, then d_req asserted in cycle 1 -> i_gnt in cycle 1, i_rvalid in cycle 4; d_gnt no earlier than cycle 5.
- reset asserted in cycle 2 of an instruction read -> no i_rvalid; all outputs 0 in cycle 3; a new i_req after reset is granted normally.
- ARB_ALIGN_CHECK_EN defined, d_addr=0x102 -> d_gnt=1, err=1, mem_en=0 in cycle 1; no d_rvalid; IDLE in cycle 2.

Source files
------------

// File: rtl/unified_mem_arbiter.sv
// -----------------------------------------------------------------------------
// unified_mem_arbiter
//
// Shares one single-ported unified memory between the MIPS core's
// instruction-fetch port (i_*) and its data port (d_*). One access is in
// flight at a time. Data has fixed priority over instruction. A starvation
// counter hands the memory to a waiting instruction fetch after STARVE_MAX
// consecutive data grants. Every output is driven straight from a flop.
//
// Parameters
//   MEM_LAT    : cycles from the mem_en cycle to the mem_rdata-valid cycle (1..15)
//   STARVE_MAX : data grants allowed while i_req waits before it wins (1..15)
//
// Ports
//   clk, reset          : clock, synchronous active-high reset
//   i_req/i_addr        : instruction read request (held until i_gnt) and address
//   i_gnt               : one-cycle instruction grant
//   i_rvalid/i_rdata    : one-cycle read-data pulse and instruction word (held)
//   d_req/d_we          : data request (held until d_gnt), 1 = write
//   d_addr/d_wdata      : data address and store data
//   d_gnt               : one-cycle data grant
//   d_rvalid/d_rdata    : one-cycle load-data pulse and load data (held)
//   mem_en/mem_we       : memory strobe and write enable (mem_we only with mem_en)
//   mem_addr/mem_wdata  : memory address and write data
//   mem_rdata           : memory read data, valid MEM_LAT cycles after mem_en
//   err                 : misaligned-grant pulse (alignment check builds only)
//   busy                : high whenever the arbiter is not in IDLE
//
// Build option
//   ARB_ALIGN_CHECK_EN : when defined, a granted address with addr[1:0] != 0
//                        is not issued to memory; the grant and err pulse
//                        together and no read data is returned. When not
//                        defined, err is constant 0 and addresses pass
//                        through unchecked.
// -----------------------------------------------------------------------------
module unified_mem_arbiter #(
  parameter int unsigned MEM_LAT    = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        err,
  output logic        busy
);

  localparam logic [3:0] LAT_M1     = 4'(MEM_LAT - 1);
  localparam logic [3:0] STARVE_TOP = 4'(STARVE_MAX);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD_WAIT,
    ST_RD_RESP,
    ST_WR
  } state_t;

  // State and bookkeeping
  state_t      r_state,      w_state_nxt;
  logic [3:0]  r_wait_cnt,   w_wait_cnt_nxt;
  logic [3:0]  r_starve_cnt, w_starve_cnt_nxt;
  logic        r_owner_i,    w_owner_i_nxt;   // 1: in-flight read belongs to instruction port

  // Registered outputs
  logic        r_i_gnt,     w_i_gnt_nxt;
  logic        r_d_gnt,     w_d_gnt_nxt;
  logic        r_i_rvalid,  w_i_rvalid_nxt;
  logic        r_d_rvalid,  w_d_rvalid_nxt;
  logic [31:0] r_i_rdata,   w_i_rdata_nxt;
  logic [31:0] r_d_rdata,   w_d_rdata_nxt;
  logic        r_mem_en,    w_mem_en_nxt;
  logic        r_mem_we,    w_mem_we_nxt;
  logic [31:0] r_mem_addr,  w_mem_addr_nxt;
  logic [31:0] r_mem_wdata, w_mem_wdata_nxt;
  logic        r_err,       w_err_nxt;
  logic        r_busy,      w_busy_nxt;

  // Arbitration: data first, unless the instruction port has been passed
  // over STARVE_MAX times while it was waiting.
  logic        w_pick_d;
  logic        w_pick_i;
  logic [31:0] w_gnt_addr;
  logic        w_misalign;

  assign w_pick_d   = d_req && !(i_req && (r_starve_cnt == STARVE_TOP));
  assign w_pick_i   = i_req && !w_pick_d;
  assign w_gnt_addr = w_pick_d ? d_addr : i_addr;

`ifdef ARB_ALIGN_CHECK_EN
  assign w_misalign = (w_gnt_addr[1:0] != 2'b00);
`else
  assign w_misalign = 1'b0;
`endif

  // NOTE: every signal this block writes gets a default before the case, so
  // no path leaves one unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt      = r_state;
    w_wait_cnt_nxt   = r_wait_cnt;
    w_starve_cnt_nxt = r_starve_cnt;
    w_owner_i_nxt    = r_owner_i;
    w_i_gnt_nxt      = 1'b0;
    w_d_gnt_nxt      = 1'b0;
    w_i_rvalid_nxt   = 1'b0;
    w_d_rvalid_nxt   = 1'b0;
    w_i_rdata_nxt    = r_i_rdata;
    w_d_rdata_nxt    = r_d_rdata;
    w_mem_en_nxt     = 1'b0;
    w_mem_we_nxt     = 1'b0;
    w_mem_addr_nxt   = r_mem_addr;
    w_mem_wdata_nxt  = r_mem_wdata;
    w_err_nxt        = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (w_pick_d || w_pick_i) begin
          w_i_gnt_nxt   = w_pick_i;
          w_d_gnt_nxt   = w_pick_d;
          w_owner_i_nxt = w_pick_i;

          if (w_pick_i) begin
            w_starve_cnt_nxt = 4'd0;
          end else if (i_req && (r_starve_cnt != STARVE_TOP)) begin
            w_starve_cnt_nxt = r_starve_cnt + 4'd1;
          end

          if (w_misalign) begin
            // Rejected access: nothing reaches memory; the single-cycle
            // state gives the one busy cycle before IDLE.
            w_err_nxt   = 1'b1;
            w_state_nxt = ST_WR;
          end else begin
            w_mem_en_nxt   = 1'b1;
            w_mem_addr_nxt = w_gnt_addr;
            if (w_pick_d && d_we) begin
              w_mem_we_nxt    = 1'b1;
              w_mem_wdata_nxt = d_wdata;
              w_state_nxt     = ST_WR;
            end else begin
              w_wait_cnt_nxt = LAT_M1;
              w_state_nxt    = ST_RD_WAIT;
            end
          end
        end
      end

      // Spans the mem_en cycle through the cycle before mem_rdata is valid.
      ST_RD_WAIT: begin
        if (r_wait_cnt == 4'd0) begin
          w_state_nxt = ST_RD_RESP;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt - 4'd1;
        end
      end

      ST_RD_RESP: begin
        if (r_owner_i) begin
          w_i_rdata_nxt  = mem_rdata;
          w_i_rvalid_nxt = 1'b1;
        end else begin
          w_d_rdata_nxt  = mem_rdata;
          w_d_rvalid_nxt = 1'b1;
        end
        w_state_nxt = ST_IDLE;
      end

      ST_WR: begin
        w_state_nxt = ST_IDLE;
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    w_busy_nxt = (w_state_nxt != ST_IDLE);
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_wait_cnt   <= 4'd0;
      r_starve_cnt <= 4'd0;
      r_owner_i    <= 1'b0;
      r_i_gnt      <= 1'b0;
      r_d_gnt      <= 1'b0;
      r_i_rvalid   <= 1'b0;
      r_d_rvalid   <= 1'b0;
      r_i_rdata    <= 32'd0;
      r_d_rdata    <= 32'd0;
      r_mem_en     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= 32'd0;
      r_mem_wdata  <= 32'd0;
      r_err        <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_wait_cnt   <= w_wait_cnt_nxt;
      r_starve_cnt <= w_starve_cnt_nxt;
      r_owner_i    <= w_owner_i_nxt;
      r_i_gnt      <= w_i_gnt_nxt;
      r_d_gnt      <= w_d_gnt_nxt;
      r_i_rvalid   <= w_i_rvalid_nxt;
      r_d_rvalid   <= w_d_rvalid_nxt;
      r_i_rdata    <= w_i_rdata_nxt;
      r_d_rdata    <= w_d_rdata_nxt;
      r_mem_en     <= w_mem_en_nxt;
      r_mem_we     <= w_mem_we_nxt;
      r_mem_addr   <= w_mem_addr_nxt;
      r_mem_wdata  <= w_mem_wdata_nxt;
      r_err        <= w_err_nxt;
      r_busy       <= w_busy_nxt;
    end
  end

  assign i_gnt     = r_i_gnt;
  assign d_gnt     = r_d_gnt;
  assign i_rvalid  = r_i_rvalid;
  assign d_rvalid  = r_d_rvalid;
  assign i_rdata   = r_i_rdata;
  assign d_rdata   = r_d_rdata;
  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign err       = r_err;
  assign busy      = r_busy;

endmodule
